// File: rtl/if_fetch_pc_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_pc_pkg
// Shared definitions for the instruction-fetch front end:
//   - fetch_state_e : fetch FSM encoding (S_BOOT / S_RUN / S_WAIT, 2 bits)
//   - default reset PC and the NOP injected into IF/ID on bubbles
// ----------------------------------------------------------------------------
package if_fetch_pc_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

endpackage : if_fetch_pc_pkg

// File: rtl/if_fetch_pc_if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with kill (bubble) and hold controls.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   kill_i             replace the slot with NOP_INSTR and clear valid
//   hold_i             keep current contents (ignored when kill_i is set)
//   pc_i/pc4_i/instr_i fetch-side values captured when neither kill nor hold
//   pc_o/pc4_o/instr_o registered IF/ID contents
//   valid_o            slot holds a real instruction
// ----------------------------------------------------------------------------
module if_id_reg #(
    parameter int                 W         = 32,
    parameter logic [W-1:0]       NOP_INSTR = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         kill_i,
    input  logic         hold_i,
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] pc4_i,
    input  logic [W-1:0] instr_i,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] pc4_o,
    output logic [W-1:0] instr_o,
    output logic         valid_o
);

    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] pc4_q, pc4_d;
    logic [W-1:0] instr_q, instr_d;
    logic         valid_q, valid_d;

    // Kill beats hold: a flushed slot must never survive a stall.
    // On kill the PC fields are left as they were; only instr/valid matter.
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (kill_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            pc_d    = pc_i;
            pc4_d   = pc4_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule : if_id_reg

// File: rtl/if_fetch_pc.sv
// ----------------------------------------------------------------------------
// if_fetch_pc
// Instruction-fetch front end: architectural PC register, next-PC selection,
// fetch FSM and the IF/ID boundary register.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc_addr                       current PC (to PC+4 adder and imem)
//   pc_plus4                      external adder result for pc_addr
//   imem_rdata, imem_ready        instruction memory read data / data valid
//   branch_taken, branch_target   redirect from EX
//   jump, jump_target             redirect from ID
//   stall                         hazard unit: hold PC and IF/ID
//   flush                         kill IF/ID contents
//   if_id_pc/pc4/instr/valid      IF/ID register contents for decode
// ----------------------------------------------------------------------------
module if_fetch_pc
    import if_fetch_pc_pkg::*;
#(
    parameter int                           instruction_width = 32,
    parameter logic [instruction_width-1:0] RESET_PC          = DEFAULT_RESET_PC,
    parameter logic [instruction_width-1:0] NOP_INSTR         = DEFAULT_NOP_INSTR
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [instruction_width-1:0] pc_addr,
    input  logic [instruction_width-1:0] pc_plus4,
    input  logic [instruction_width-1:0] imem_rdata,
    input  logic                         imem_ready,
    input  logic                         branch_taken,
    input  logic [instruction_width-1:0] branch_target,
    input  logic                         jump,
    input  logic [instruction_width-1:0] jump_target,
    input  logic                         stall,
    input  logic                         flush,
    output logic [instruction_width-1:0] if_id_pc,
    output logic [instruction_width-1:0] if_id_pc4,
    output logic [instruction_width-1:0] if_id_instr,
    output logic                         if_id_valid
);

    localparam int W = instruction_width;

    fetch_state_e state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic         redirect;
    logic         ifid_kill;
    logic         ifid_hold;

    assign redirect = branch_taken | jump;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ifid_kill = 1'b1;
        ifid_hold = 1'b0;
        case (state_q)
            // First cycle after reset: PC settles at RESET_PC, nothing fetched yet.
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_WAIT: begin
                // Branch resolves in EX, older than the jump in ID, so it wins.
                // Redirects bypass stall; targets are forced word-aligned.
                if (branch_taken) begin
                    pc_d = {branch_target[W-1:2], 2'b00};
                end else if (jump) begin
                    pc_d = {jump_target[W-1:2], 2'b00};
                end else if (stall || !imem_ready) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_plus4;
                end

                if (state_q == S_RUN && !redirect && !imem_ready) begin
                    state_d = S_WAIT;
                end else if (state_q == S_WAIT && (imem_ready || redirect)) begin
                    state_d = S_RUN;
                end

                // A missing imem response only bubbles IF/ID when not stalled;
                // under stall the slot simply holds.
                ifid_kill = redirect || flush || (!stall && !imem_ready);
                ifid_hold = stall;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_addr = pc_q;

    if_id_reg #(
        .W         (W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .kill_i  (ifid_kill),
        .hold_i  (ifid_hold),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4),
        .instr_i (imem_rdata),
        .pc_o    (if_id_pc),
        .pc4_o   (if_id_pc4),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

endmodule : if_fetch_pc

// File: tb/tb_if_fetch_pc.sv
module tb_if_fetch_pc;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] MAGIC = 32'hC0DE_0000;

    typedef struct packed {
        logic        rst;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        st;
        logic        fl;
        logic        rdy;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        vld;
        logic [31:0] ifpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [31:0] pc_addr, pc_plus4, imem_rdata;
    logic        imem_ready, branch_taken, jump, stall, flush;
    logic [31:0] branch_target, jump_target;
    logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
    logic        if_id_valid;

    logic [31:0] pc_addr2, pc_plus4_2, imem_rdata2;
    logic [31:0] if_id_pc2, if_id_pc4_2, if_id_instr2;
    logic        if_id_valid2;

    int ntests = 0;
    int nfail  = 0;

    stim_t stimq[$];
    exp_t  pendq[$];
    exp_t  sb[$];

    always #5 clk = ~clk;

    // External PC+4 adder and a recognisable instruction per address.
    assign pc_plus4    = pc_addr + 32'd4;
    assign imem_rdata  = pc_addr ^ MAGIC;
    assign pc_plus4_2  = pc_addr2 + 32'd4;
    assign imem_rdata2 = pc_addr2 ^ MAGIC;

    if_fetch_pc dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_plus4(pc_plus4),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .stall(stall), .flush(flush),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid)
    );

    if_fetch_pc #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2), .pc_addr(pc_addr2), .pc_plus4(pc_plus4_2),
        .imem_rdata(imem_rdata2), .imem_ready(imem_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .stall(stall), .flush(flush),
        .if_id_pc(if_id_pc2), .if_id_pc4(if_id_pc4_2), .if_id_instr(if_id_instr2),
        .if_id_valid(if_id_valid2)
    );

    task automatic apply(input stim_t s);
        rst           = s.rst;
        branch_taken  = s.br;
        branch_target = s.bt;
        jump          = s.jp;
        jump_target   = s.jt;
        stall         = s.st;
        flush         = s.fl;
        imem_ready    = s.rdy;
    endtask

    task automatic put(input stim_t s, input exp_t e);
        stimq.push_back(s);
        pendq.push_back(e);
    endtask

    // Idle stimulus: no reset, no redirect, imem ready.
    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    task automatic test_reset;
        exp_t e;
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        apply(s);
        sb.push_back('{pc: 32'h0, vld: 1'b0, ifpc: 32'h0});
        @(posedge clk); #1;
        e = sb.pop_front();
        ntests++; if (pc_addr !== e.pc) begin nfail++; $display("FAIL reset pc_addr got %h exp %h", pc_addr, e.pc); end
        ntests++; if (if_id_valid !== e.vld) begin nfail++; $display("FAIL reset if_id_valid got %b exp %b", if_id_valid, e.vld); end
        ntests++; if (if_id_pc !== e.ifpc) begin nfail++; $display("FAIL reset if_id_pc got %h exp %h", if_id_pc, e.ifpc); end
        ntests++; if (if_id_pc4 !== 32'h0) begin nfail++; $display("FAIL reset if_id_pc4 got %h exp 0", if_id_pc4); end
        ntests++; if (if_id_instr !== NOP) begin nfail++; $display("FAIL reset if_id_instr got %h exp %h", if_id_instr, NOP); end
    endtask

    // Runs the queued steps for the main DUT; comparisons inline.
    task automatic run_main_steps_test(input string name);
        stim_t s;
        exp_t  e;
        while (stimq.size() != 0) begin
            s = stimq.pop_front();
            apply(s);
            sb.push_back(pendq.pop_front());
            @(posedge clk); #1;
            e = sb.pop_front();
            ntests++;
            if (pc_addr !== e.pc) begin nfail++; $display("FAIL %s pc_addr got %h exp %h", name, pc_addr, e.pc); end
            ntests++;
            if (if_id_valid !== e.vld) begin nfail++; $display("FAIL %s if_id_valid got %b exp %b (pc %h)", name, if_id_valid, e.vld, e.pc); end
            if (e.vld) begin
                ntests++;
                if (if_id_pc !== e.ifpc) begin nfail++; $display("FAIL %s if_id_pc got %h exp %h", name, if_id_pc, e.ifpc); end
                ntests++;
                if (if_id_pc4 !== e.ifpc + 32'd4) begin nfail++; $display("FAIL %s if_id_pc4 got %h exp %h", name, if_id_pc4, e.ifpc + 32'd4); end
                ntests++;
                if (if_id_instr !== (e.ifpc ^ MAGIC)) begin nfail++; $display("FAIL %s if_id_instr got %h exp %h", name, if_id_instr, e.ifpc ^ MAGIC); end
            end else begin
                ntests++;
                if (if_id_instr !== NOP) begin nfail++; $display("FAIL %s bubble if_id_instr got %h exp %h", name, if_id_instr, NOP); end
            end
        end
    endtask

    task automatic test_sequential;
        put(idle(), '{pc: 32'h0, vld: 1'b0, ifpc: 32'h0});   // boot cycle
        put(idle(), '{pc: 32'h4, vld: 1'b1, ifpc: 32'h0});
        put(idle(), '{pc: 32'h8, vld: 1'b1, ifpc: 32'h4});
        run_main_steps_test("seq");
    endtask

    task automatic test_branch;
        stim_t s;
        s = idle(); s.br = 1'b1; s.bt = 32'h0000_0103;
        put(s, '{pc: 32'h100, vld: 1'b0, ifpc: 32'h0});
        put(idle(), '{pc: 32'h104, vld: 1'b1, ifpc: 32'h100});
        put(idle(), '{pc: 32'h108, vld: 1'b1, ifpc: 32'h104});
        // branch and jump together: branch wins, target aligned
        s = idle(); s.br = 1'b1; s.bt = 32'h0000_000E; s.jp = 1'b1; s.jt = 32'h300;
        put(s, '{pc: 32'h0C, vld: 1'b0, ifpc: 32'h0});
        put(idle(), '{pc: 32'h10, vld: 1'b1, ifpc: 32'h0C});
        run_main_steps_test("branch");
    endtask

    task automatic test_stall;
        stim_t s;
        s = idle(); s.st = 1'b1;
        for (int i = 0; i < 3; i++) put(s, '{pc: 32'h10, vld: 1'b1, ifpc: 32'h0C});
        put(idle(), '{pc: 32'h14, vld: 1'b1, ifpc: 32'h10});
        put(idle(), '{pc: 32'h18, vld: 1'b1, ifpc: 32'h14});
        run_main_steps_test("stall");
    endtask

    task automatic test_stall_redirect;
        stim_t s;
        s = idle(); s.st = 1'b1; s.jp = 1'b1; s.jt = 32'h200;
        put(s, '{pc: 32'h200, vld: 1'b0, ifpc: 32'h0});
        put(idle(), '{pc: 32'h204, vld: 1'b1, ifpc: 32'h200});
        // flush beats stall; PC held by stall
        s = idle(); s.st = 1'b1; s.fl = 1'b1;
        put(s, '{pc: 32'h204, vld: 1'b0, ifpc: 32'h0});
        put(idle(), '{pc: 32'h208, vld: 1'b1, ifpc: 32'h204});
        s = idle(); s.jp = 1'b1; s.jt = 32'h20;
        put(s, '{pc: 32'h20, vld: 1'b0, ifpc: 32'h0});
        run_main_steps_test("stall_redir");
    endtask

    task automatic test_wait;
        stim_t s;
        s = idle(); s.rdy = 1'b0;
        put(s, '{pc: 32'h20, vld: 1'b0, ifpc: 32'h0});
        put(s, '{pc: 32'h20, vld: 1'b0, ifpc: 32'h0});
        put(idle(), '{pc: 32'h24, vld: 1'b1, ifpc: 32'h20});
        put(s, '{pc: 32'h24, vld: 1'b0, ifpc: 32'h0});
        s.br = 1'b1; s.bt = 32'h80;   // redirect while waiting
        put(s, '{pc: 32'h80, vld: 1'b0, ifpc: 32'h0});
        put(idle(), '{pc: 32'h84, vld: 1'b1, ifpc: 32'h80});
        // reset mid-run returns to RESET_PC and re-boots
        s = idle(); s.rst = 1'b1;
        put(s, '{pc: 32'h0, vld: 1'b0, ifpc: 32'h0});
        put(idle(), '{pc: 32'h0, vld: 1'b0, ifpc: 32'h0});
        put(idle(), '{pc: 32'h4, vld: 1'b1, ifpc: 32'h0});
        run_main_steps_test("wait_rst");
    endtask

    task automatic test_wrap;
        logic  r2[$];
        exp_t  e;
        apply(idle());
        r2 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        pendq.push_back('{pc: 32'hFFFF_FFF8, vld: 1'b0, ifpc: 32'h0});
        pendq.push_back('{pc: 32'hFFFF_FFF8, vld: 1'b0, ifpc: 32'h0});
        pendq.push_back('{pc: 32'hFFFF_FFFC, vld: 1'b1, ifpc: 32'hFFFF_FFF8});
        pendq.push_back('{pc: 32'h0000_0000, vld: 1'b1, ifpc: 32'hFFFF_FFFC});
        pendq.push_back('{pc: 32'h0000_0004, vld: 1'b1, ifpc: 32'h0000_0000});
        pendq.push_back('{pc: 32'hFFFF_FFF8, vld: 1'b0, ifpc: 32'h0});
        while (r2.size() != 0) begin
            rst2 = r2.pop_front();
            sb.push_back(pendq.pop_front());
            @(posedge clk); #1;
            e = sb.pop_front();
            ntests++;
            if (pc_addr2 !== e.pc) begin nfail++; $display("FAIL wrap pc_addr got %h exp %h", pc_addr2, e.pc); end
            ntests++;
            if (if_id_valid2 !== e.vld) begin nfail++; $display("FAIL wrap if_id_valid got %b exp %b", if_id_valid2, e.vld); end
            if (e.vld) begin
                ntests++;
                if (if_id_pc2 !== e.ifpc) begin nfail++; $display("FAIL wrap if_id_pc got %h exp %h", if_id_pc2, e.ifpc); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst2 = 1'b1;
        apply(idle());
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_sequential;
        test_branch;
        test_stall;
        test_stall_redirect;
        test_wait;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule : tb_if_fetch_pc
